// File: rtl/sd_arb_pkg.sv
// -----------------------------------------------------------------------------
// sd_arb_pkg
// Shared types and constants for the block-device request arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, XFER, DONE)
//   arb_op_t    : operation type latched at grant time (read / write)
//   MAX_NCH     : largest supported number of drive channels
//   idx_w()     : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package sd_arb_pkg;

    localparam int MAX_NCH = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    // A single channel still needs a 1-bit index so the ports stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting at last+1 (mod N) and returns the first requesting index.
//   req   in  N  : request vector
//   last  in  IW : index granted most recently
//   valid out 1  : at least one request present
//   idx   out IW : chosen index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Offset 1 is checked first, offset N (last itself) last, so the channel
    // just served has the lowest priority in the next pass.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!valid && req[(32'(last) + k) % 32'(N)]) begin
                valid = 1'b1;
                idx   = IW'((32'(last) + k) % 32'(N));
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// -----------------------------------------------------------------------------
// sd_req_arbiter
// Block-device request arbiter between the virtual drives and the hps_io SD
// interface. Latches per-channel read/write request pulses, grants them one at
// a time in round-robin order, runs the sd_rd/sd_wr + sd_ack handshake for the
// granted channel and holds a per-channel busy (CPU wait) while work remains.
//   clk_sys    in  1   : system clock
//   reset_n    in  1   : asynchronous active-low reset
//   soft_reset in  1   : synchronous clear
//   req_rd     in  NCH : read request pulse per channel
//   req_wr     in  NCH : write request pulse per channel
//   mounted    in  NCH : image mounted per channel
//   protect    in  NCH : image read-only per channel
//   sd_rd      out NCH : read strobe to hps_io
//   sd_wr      out NCH : write strobe to hps_io
//   sd_ack     in  NCH : ack from hps_io
//   busy       out NCH : CPU wait per channel
//   done       out NCH : one-cycle pulse on completion
//   err        out NCH : one-cycle pulse on rejection or timeout abort
// -----------------------------------------------------------------------------
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int               NCH   = 3,
    parameter int               TMO_W = 24,
    parameter logic [TMO_W-1:0] TMO   = 24'hFFFFFF
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    input  logic           soft_reset,
    input  logic [NCH-1:0] req_rd,
    input  logic [NCH-1:0] req_wr,
    input  logic [NCH-1:0] mounted,
    input  logic [NCH-1:0] protect,
    output logic [NCH-1:0] sd_rd,
    output logic [NCH-1:0] sd_wr,
    input  logic [NCH-1:0] sd_ack,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done,
    output logic [NCH-1:0] err
);

    localparam int IW = idx_w(NCH);

    arb_state_t       state, state_n;
    arb_op_t          op, op_n;
    logic [IW-1:0]    gnt, gnt_n;
    logic [IW-1:0]    last, last_n;
    logic [NCH-1:0]   pend_rd, pend_rd_n;
    logic [NCH-1:0]   pend_wr, pend_wr_n;
    logic [NCH-1:0]   old_ack;
    logic [TMO_W-1:0] cnt, cnt_n;
    logic [NCH-1:0]   busy_n, err_n;

    logic [NCH-1:0]   pend_any;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [NCH-1:0]   gnt_oh;
    logic [NCH-1:0]   set_rd, set_wr, reject;
    logic [NCH-1:0]   clr_rd, clr_wr, abort_oh;
    logic             ack_rise, ack_fall, tmo_hit;

    assign pend_any = pend_rd | pend_wr;
    assign gnt_oh   = NCH'(1) << gnt;

    rr_pick #(
        .N  (NCH),
        .IW (IW)
    ) u_pick (
        .req   (pend_any),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Requests on unmounted images, and writes to protected ones, never reach
    // the pending bits; they only produce an err pulse.
    assign set_rd = req_rd & mounted;
    assign set_wr = req_wr & mounted & ~protect;
    assign reject = ((req_rd | req_wr) & ~mounted) | (req_wr & protect);

    assign ack_rise = ~old_ack[gnt] &  sd_ack[gnt];
    assign ack_fall =  old_ack[gnt] & ~sd_ack[gnt];

    // The counter holds the number of cycles already spent in the current
    // state, so matching TMO-1 means TMO cycles have elapsed by the next edge.
    assign tmo_hit = (TMO != '0) && (cnt == TMO - TMO_W'(1));

    always_comb begin
        state_n  = state;
        op_n     = op;
        gnt_n    = gnt;
        last_n   = last;
        clr_rd   = '0;
        clr_wr   = '0;
        abort_oh = '0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n   = pick_idx;
                    last_n  = pick_idx;
                    op_n    = pend_rd[pick_idx] ? OP_RD : OP_WR;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_rise || tmo_hit) begin
                    if (op == OP_RD) begin
                        clr_rd = gnt_oh;
                    end else begin
                        clr_wr = gnt_oh;
                    end
                end
                if (ack_rise) begin
                    state_n = XFER;
                end else if (tmo_hit) begin
                    abort_oh = gnt_oh;
                    state_n  = IDLE;
                end
            end
            XFER: begin
                // The pending bit was already cleared at the ack rise; a bit
                // seen here is a fresh request and must survive an abort.
                if (ack_fall) begin
                    state_n = DONE;
                end else if (tmo_hit) begin
                    abort_oh = gnt_oh;
                    state_n  = IDLE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A request landing on the same cycle as the clear wins.
        pend_rd_n = (pend_rd & ~clr_rd) | set_rd;
        pend_wr_n = (pend_wr & ~clr_wr) | set_wr;

        if (state_n != state) begin
            cnt_n = '0;
        end else if (state == REQ || state == XFER) begin
            cnt_n = cnt + TMO_W'(1);
        end else begin
            cnt_n = '0;
        end

        busy_n = pend_rd_n | pend_wr_n
               | ((state_n != IDLE) ? (NCH'(1) << gnt_n) : '0);
        err_n  = reject | abort_oh;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            op      <= OP_RD;
            gnt     <= '0;
            last    <= IW'(NCH - 1);
            pend_rd <= '0;
            pend_wr <= '0;
            old_ack <= '0;
            cnt     <= '0;
            busy    <= '0;
            err     <= '0;
        end else if (soft_reset) begin
            state   <= IDLE;
            op      <= OP_RD;
            gnt     <= '0;
            last    <= IW'(NCH - 1);
            pend_rd <= '0;
            pend_wr <= '0;
            old_ack <= '0;
            cnt     <= '0;
            busy    <= '0;
            err     <= '0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            gnt     <= gnt_n;
            last    <= last_n;
            pend_rd <= pend_rd_n;
            pend_wr <= pend_wr_n;
            old_ack <= sd_ack;
            cnt     <= cnt_n;
            busy    <= busy_n;
            err     <= err_n;
        end
    end

    // Strobes and done decode straight from registered state, so an async
    // reset removes them immediately and at most one strobe bit can be high.
    always_comb begin
        sd_rd = '0;
        sd_wr = '0;
        done  = '0;
        if (state == REQ) begin
            if (op == OP_RD) begin
                sd_rd = gnt_oh;
            end else begin
                sd_wr = gnt_oh;
            end
        end
        if (state == DONE) begin
            done = gnt_oh;
        end
    end

endmodule
